// File: rtl/seq_bus_pkg.sv
// seq_bus_pkg: shared bus-cycle state and owner encodings for the sequential bus controller
package seq_bus_pkg;
   typedef enum logic [2:0] {IDLE, T1, T2, T3, T4} state_t;
   typedef enum logic {OWN_CPU, OWN_DMA} owner_t;
endpackage

// File: rtl/seq_bus_arb.sv
// seq_bus_arb: strict-priority (DMA over CPU) grant decision
// Ports: cpu_req/dma_req requests; excl/last mask the requester acked this edge; grant_cpu/grant_dma one-hot-or-zero grants
module seq_bus_arb import seq_bus_pkg::*; (
   input  logic   cpu_req,
   input  logic   dma_req,
   input  logic   excl,
   input  owner_t last,
   output logic   grant_cpu,
   output logic   grant_dma
);
   assign grant_dma = dma_req && !(excl && last == OWN_DMA);
   assign grant_cpu = cpu_req && !grant_dma && !(excl && last == OWN_CPU);
endmodule

// File: rtl/seq_bus_ctrl.sv
// seq_bus_ctrl: T1..T4 memory-cycle sequencer arbitrating a CPU and a DMA reader onto one bus
// Ports: clk/res clock and sync reset; cpu_* CPU request/ack/data; dma_* DMA read request/ack/grant/data;
//        bus_a/bus_dout/bus_din/bus_oe bus address and data; n_mreq/n_rd/n_wr strobes; wait_n stall input
module seq_bus_ctrl import seq_bus_pkg::*; #(
   parameter int AW = 16,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          res,
   input  logic          cpu_req,
   input  logic          cpu_wr,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_ack,
   input  logic          dma_req,
   input  logic [AW-1:0] dma_addr,
   output logic [DW-1:0] dma_rdata,
   output logic          dma_ack,
   output logic          dma_gnt,
   output logic [AW-1:0] bus_a,
   output logic [DW-1:0] bus_dout,
   input  logic [DW-1:0] bus_din,
   output logic          bus_oe,
   output logic          n_mreq,
   output logic          n_rd,
   output logic          n_wr,
   input  logic          wait_n
);
   state_t        st, st_nx;
   owner_t        own;
   logic          wr, g_cpu, g_dma, start, act;
   logic [DW-1:0] rdata;
   seq_bus_arb u_arb (
      .cpu_req   (cpu_req),
      .dma_req   (dma_req),
      .excl      (st == T4),
      .last      (own),
      .grant_cpu (g_cpu),
      .grant_dma (g_dma)
   );
   // Grants only matter where arbitration is allowed; T4 chains straight into T1.
   assign start = (st == IDLE || st == T4) && (g_cpu || g_dma);
   always_comb begin
      st_nx = IDLE;
      unique case (st)
         IDLE, T4: st_nx = start ? T1 : IDLE;
         T1:       st_nx = T2;
         T2:       st_nx = T3;
         T3:       st_nx = wait_n ? T4 : T3;
         default:  st_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (res) begin
         st       <= IDLE;
         own      <= OWN_CPU;
         wr       <= 1'b0;
         bus_a    <= '0;
         bus_dout <= '0;
         rdata    <= '0;
      end else begin
         st <= st_nx;
         if (start) begin
            own   <= g_dma ? OWN_DMA : OWN_CPU;
            wr    <= g_cpu && cpu_wr;
            bus_a <= g_dma ? dma_addr : cpu_addr;
            if (g_cpu) bus_dout <= cpu_wdata;
         end
         if (st == T3 && wait_n && !wr) rdata <= bus_din;
      end
   end
   assign act       = st inside {T1, T2, T3};
   assign n_mreq    = !act;
   assign n_rd      = !(act && !wr);
   assign n_wr      = !(wr && st inside {T2, T3});
   assign bus_oe    = wr && st inside {T2, T3, T4};
   assign cpu_ack   = st == T4 && own == OWN_CPU;
   assign dma_ack   = st == T4 && own == OWN_DMA;
   assign dma_gnt   = st != IDLE && own == OWN_DMA;
   assign cpu_rdata = rdata;
   assign dma_rdata = rdata;
endmodule

// File: tb/tb_seq_bus_ctrl.sv
// tb_seq_bus_ctrl: directed cycle-pattern tests plus randomized scoreboard run against a bus memory model
module tb_seq_bus_ctrl;
   logic        clk, res, cpu_req, cpu_wr, cpu_ack, dma_req, dma_ack, dma_gnt;
   logic        bus_oe, n_mreq, n_rd, n_wr, wait_n;
   logic [15:0] cpu_addr, dma_addr, bus_a;
   logic [7:0]  cpu_wdata, cpu_rdata, dma_rdata, bus_dout, bus_din;
   logic        force_en, sb_en;
   logic [7:0]  force_val;
   int          checks = 0, errors = 0, drv_done = 0;
   logic [15:0] l_mreq, l_rd, l_wr, l_oe, l_cack, l_dack, l_gnt;
   logic [7:0]  c_rd, d_rd;
   typedef struct {logic wr; logic [15:0] a; logic [7:0] d; logic [7:0] r;} cpu_t;
   cpu_t        cq[$];
   logic [15:0] dq[$];

   seq_bus_ctrl #(.AW(16), .DW(8)) dut (
      .clk(clk), .res(res), .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .dma_req(dma_req),
      .dma_addr(dma_addr), .dma_rdata(dma_rdata), .dma_ack(dma_ack), .dma_gnt(dma_gnt),
      .bus_a(bus_a), .bus_dout(bus_dout), .bus_din(bus_din), .bus_oe(bus_oe),
      .n_mreq(n_mreq), .n_rd(n_rd), .n_wr(n_wr), .wait_n(wait_n)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   function automatic logic [7:0] mem_f(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h3C;
   endfunction
   assign bus_din = force_en ? force_val : mem_f(bus_a);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Logs n cycles starting at the grant edge; acked requesters drop req immediately.
   task automatic run_log(input int n, input int w_at, input int r_at, input int d_at);
      l_mreq = 0; l_rd = 0; l_wr = 0; l_oe = 0; l_cack = 0; l_dack = 0; l_gnt = 0;
      c_rd = 0; d_rd = 0;
      wait_n = (w_at <= 0);
      @(posedge clk);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         l_mreq[i] = n_mreq; l_rd[i] = n_rd; l_wr[i] = n_wr; l_oe[i] = bus_oe;
         l_cack[i] = cpu_ack; l_dack[i] = dma_ack; l_gnt[i] = dma_gnt;
         if (cpu_ack) begin c_rd = cpu_rdata; cpu_req = 0; end
         if (dma_ack) begin d_rd = dma_rdata; dma_req = 0; end
         if (i == d_at) cpu_req = 0;
         if (i == r_at) begin res = 1; cpu_req = 0; end
         else if (r_at >= 0 && i == r_at + 1) res = 0;
         if (w_at > 0 && i >= w_at) wait_n = 1;
      end
   endtask

   task automatic cpu_drv(input int n);
      cpu_t e;
      int t, gap;
      for (int k = 0; k < n; k++) begin
         e.wr = 1'($urandom_range(0, 1)); e.a = 16'($urandom); e.d = 8'($urandom); e.r = mem_f(e.a);
         cq.push_back(e);
         cpu_wr = e.wr; cpu_addr = e.a; cpu_wdata = e.d; cpu_req = 1;
         t = 0;
         @(negedge clk);
         while (!cpu_ack && t < 400) begin @(negedge clk); t++; end
         if (!cpu_ack) begin
            checks++; errors++;
            $display("FAIL cpu_timeout: no cpu_ack within %0d cycles", t);
            break;
         end
         @(posedge clk); #1;
         gap = $urandom_range(0, 3);
         if (gap != 0) begin cpu_req = 0; repeat (gap) @(posedge clk); #1; end
      end
      cpu_req = 0;
      drv_done++;
   endtask

   task automatic dma_drv(input int n);
      logic [15:0] a;
      int t, gap;
      for (int k = 0; k < n; k++) begin
         a = 16'($urandom);
         dq.push_back(a);
         dma_addr = a; dma_req = 1;
         t = 0;
         @(negedge clk);
         while (!dma_ack && t < 400) begin @(negedge clk); t++; end
         if (!dma_ack) begin
            checks++; errors++;
            $display("FAIL dma_timeout: no dma_ack within %0d cycles", t);
            break;
         end
         @(posedge clk); #1;
         gap = $urandom_range(0, 4);
         if (gap != 0) begin dma_req = 0; repeat (gap) @(posedge clk); #1; end
      end
      dma_req = 0;
      drv_done++;
   endtask

   always @(negedge clk) begin
      cpu_t        e;
      logic [15:0] a;
      if (sb_en && !res) begin
         if (cpu_ack) begin
            if (cq.size() == 0) begin
               checks++; errors++;
               $display("FAIL cpu_unexpected_ack: got ack expected none");
            end else begin
               e = cq.pop_front();
               chk("cpu_addr", bus_a, e.a);
               chk("cpu_side_gnt", {dma_gnt, dma_ack}, 0);
               if (e.wr) chk("cpu_wdata", bus_dout, e.d);
               else chk("cpu_rdata", cpu_rdata, e.r);
            end
         end
         if (dma_ack) begin
            if (dq.size() == 0) begin
               checks++; errors++;
               $display("FAIL dma_unexpected_ack: got ack expected none");
            end else begin
               a = dq.pop_front();
               chk("dma_addr", bus_a, a);
               chk("dma_gnt", dma_gnt, 1);
               chk("dma_rdata", dma_rdata, mem_f(a));
            end
         end
         if (!n_wr) chk("wr_strobe_oe_rd", {bus_oe, n_rd, n_mreq}, 3'b110);
      end
   end

   initial begin
      res = 1; cpu_req = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
      dma_req = 0; dma_addr = 0; wait_n = 1; force_en = 0; force_val = 0; sb_en = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_strobes", {n_mreq, n_rd, n_wr, bus_oe}, 4'b1110);
      chk("rst_acks", {cpu_ack, dma_ack, dma_gnt}, 0);
      chk("rst_bus_a", bus_a, 0);
      chk("rst_bus_dout", bus_dout, 0);
      chk("rst_rdata", cpu_rdata, 0);
      @(posedge clk); #1; res = 0;

      @(posedge clk); #1;
      force_en = 1; force_val = 8'h5A;
      cpu_wr = 0; cpu_addr = 16'hC000; cpu_req = 1;
      run_log(6, 0, -1, -1);
      chk("rd_mreq", l_mreq, 16'h38);
      chk("rd_n_rd", l_rd, 16'h38);
      chk("rd_n_wr", l_wr, 16'h3F);
      chk("rd_oe", l_oe, 0);
      chk("rd_cack", l_cack, 16'h08);
      chk("rd_data", c_rd, 8'h5A);
      chk("rd_bus_a", bus_a, 16'hC000);
      force_en = 0;

      @(posedge clk); #1;
      cpu_wr = 1; cpu_addr = 16'hFF40; cpu_wdata = 8'h91; cpu_req = 1;
      run_log(6, 0, -1, -1);
      chk("wr_n_wr", l_wr, 16'h39);
      chk("wr_oe", l_oe, 16'h0E);
      chk("wr_n_rd", l_rd, 16'h3F);
      chk("wr_mreq", l_mreq, 16'h38);
      chk("wr_cack", l_cack, 16'h08);
      chk("wr_bus_dout", bus_dout, 8'h91);
      chk("wr_rdata_held", cpu_rdata, 8'h5A);

      @(posedge clk); #1;
      cpu_wr = 0; cpu_addr = 16'h1234; dma_addr = 16'h8000; cpu_req = 1; dma_req = 1;
      run_log(10, 0, -1, -1);
      chk("both_gnt", l_gnt, 16'h00F);
      chk("both_dack", l_dack, 16'h008);
      chk("both_cack", l_cack, 16'h080);
      chk("both_mreq", l_mreq, 16'h388);
      chk("both_dma_data", d_rd, 8'hBC);
      chk("both_cpu_data", c_rd, 8'h1A);

      @(posedge clk); #1;
      cpu_wr = 0; cpu_addr = 16'h00AA; cpu_req = 1;
      run_log(9, 5, -1, -1);
      chk("wait_n_rd", l_rd, 16'h1C0);
      chk("wait_mreq", l_mreq, 16'h1C0);
      chk("wait_cack", l_cack, 16'h040);
      chk("wait_data", c_rd, 8'h96);

      @(posedge clk); #1;
      cpu_wr = 1; cpu_addr = 16'h2000; cpu_wdata = 8'h77; cpu_req = 1;
      run_log(5, 0, 1, -1);
      chk("rst_mid_n_wr", l_wr, 16'h1D);
      chk("rst_mid_oe", l_oe, 16'h02);
      chk("rst_mid_mreq", l_mreq, 16'h1C);
      chk("rst_mid_cack", l_cack, 0);
      chk("rst_mid_dout", bus_dout, 0);
      chk("rst_mid_bus_a", bus_a, 0);

      @(posedge clk); #1;
      cpu_wr = 0; cpu_addr = 16'h0F0F; cpu_req = 1;
      run_log(6, 0, -1, 1);
      chk("drop_cack", l_cack, 16'h08);
      chk("drop_mreq", l_mreq, 16'h38);
      chk("drop_data", c_rd, 8'h3C);

      @(posedge clk); #1;
      sb_en = 1;
      fork
         cpu_drv(40);
         dma_drv(30);
      join_none
      while (drv_done < 2) begin
         @(posedge clk); #1;
         wait_n = ($urandom_range(0, 3) != 0);
      end
      wait_n = 1;
      repeat (10) @(posedge clk);
      sb_en = 0;
      chk("cpu_queue_drained", cq.size(), 0);
      chk("dma_queue_drained", dq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/seq_bus_ctrl.md
SEQ_BUS_CTRL -- requirements
Module: seq_bus_ctrl

Interface
REQ-001 SHALL have parameter AW, default 16, address width.
REQ-002 SHALL have parameter DW, default 8, data width.
REQ-003 SHALL have one clock; reset is synchronous and active-high (ports clk, res).
REQ-004 clk  in  1  sole clock; all state changes on posedge.
REQ-005 res  in  1  synchronous active-high reset.
REQ-006 cpu_req  in  1  CPU requests a bus M-cycle; held until cpu_ack.
REQ-007 cpu_wr  in  1  1=write, 0=read; sampled with cpu_req at grant.
REQ-008 cpu_addr  in  AW  CPU address; cpu_wdata  in  DW  CPU write data.
REQ-009 cpu_rdata  out  DW  read data, valid while cpu_ack high.
REQ-010 cpu_ack  out  1  one-cycle pulse in T4 of a CPU-owned cycle.
REQ-011 dma_req  in  1  DMA read request; dma_addr  in  AW  DMA address.
REQ-012 dma_rdata  out  DW  read data, valid while dma_ack high; dma_ack  out  1  one-cycle pulse in T4 of a DMA-owned cycle.
REQ-013 dma_gnt  out  1  high T1..T4 of every DMA-owned cycle.
REQ-014 bus_a  out  AW  latched address; bus_dout  out  DW  write data; bus_din  in  DW  read data; bus_oe  out  1  data drive enable.
REQ-015 n_mreq, n_rd, n_wr  out  1 each  active-low strobes; wait_n  in  1  active-low wait (stall) request.

Function
REQ-016 SHALL implement FSM states IDLE, T1, T2, T3, T4.
REQ-017 IDLE: if dma_req or cpu_req high at edge, next state T1 with owner latched; else stay IDLE.
REQ-018 Arbitration SHALL occur only in IDLE and T4; dma_req wins over cpu_req (strict priority); no preemption mid-cycle.
REQ-019 On entry to T1 SHALL latch owner, direction (DMA always read), address into bus_a, write data into bus_dout; values held stable through T4.
REQ-020 T1->T2->T3 unconditional; T3->T4 only when wait_n high at edge, else stay T3 (unbounded wait states).
REQ-021 n_mreq low in T1, T2, T3; high in IDLE and T4.
REQ-022 Read: n_rd low T1..T3; n_wr high throughout; bus_oe low.
REQ-023 Write: n_wr low T2..T3 only; bus_oe high T2..T4; n_rd high throughout.
REQ-024 Read data SHALL be captured from bus_din at the T3->T4 edge into a DW register driving both cpu_rdata and dma_rdata; held until next capture.
REQ-025 Exactly one of cpu_ack/dma_ack pulses, in T4, per completed cycle.
REQ-026 T4: if any request pending (excluding the requester just acked, whose req is ignored that edge), next state T1 (back-to-back, no IDLE gap); else IDLE.
REQ-027 Latency: req sampled in IDLE at edge k -> T1 at k+1, ack high during cycle k+4 (zero wait states).
REQ-028 Requester dropping req after grant SHALL NOT abort; cycle completes and ack still pulses.
REQ-029 Simultaneous cpu_req and dma_req in IDLE: DMA cycle first, CPU cycle immediately follows.

Reset
REQ-030 res high at an edge SHALL force IDLE regardless of state, including mid-cycle and mid-wait.
REQ-031 Reset values: n_mreq=n_rd=n_wr=1, bus_oe=0, cpu_ack=dma_ack=dma_gnt=0, bus_a=0, bus_dout=0, read-data register=0.
REQ-032 Aborted cycle SHALL produce no ack; requesters re-arbitrate after res falls.

Structure
REQ-033 State encoding (IDLE..T4) and owner encoding (CPU, DMA) SHALL reside in shared package seq_bus_pkg.
REQ-034 Priority decision SHALL be sub-module seq_bus_arb (combinational: cpu_req, dma_req, exclude-last -> grant_cpu, grant_dma).
REQ-035 All outputs SHALL be registered or decoded from registered state only; no combinational path from request inputs to strobes.

Verification
REQ-036 CPU read addr 0xC000, bus_din=0x5A, wait_n=1 -> n_rd low 3 cycles, cpu_ack at k+4, cpu_rdata=0x5A.
REQ-037 CPU write 0xFF40 data 0x91 -> n_wr low T2..T3 only, bus_oe high T2..T4, bus_dout=0x91, n_rd never low.
REQ-038 cpu_req and dma_req (addr 0x8000) together in IDLE -> dma_gnt/dma_ack first, then CPU T1 directly after T4, no IDLE cycle.
REQ-039 wait_n low 3 cycles during T3 -> T3 held 4 cycles, strobes held low, ack delayed by 3 cycles.
REQ-040 res pulsed during T2 of CPU write -> next cycle IDLE, all strobes high, bus_oe=0, no cpu_ack.
REQ-041 cpu_req dropped in T2 -> cycle completes, cpu_ack pulses once, FSM returns IDLE.
